// File: rtl/ltc2292_pkg.sv
// Shared types and constants for the LTC2292 capture sequencer.
package ltc2292_pkg;

  localparam int unsigned ADC_W  = 12;
  localparam int unsigned PAIR_W = 2 * ADC_W;

  typedef struct packed {
    logic [ADC_W-1:0] a;
    logic [ADC_W-1:0] b;
  } pair_t;

  typedef logic [2:0] state_t;

  localparam state_t StShdn    = 3'd0;
  localparam state_t StWake    = 3'd1;
  localparam state_t StFlush   = 3'd2;
  localparam state_t StCapture = 3'd3;
  localparam state_t StIdle    = 3'd4;

endpackage

// File: rtl/ltc2292_ctrl_if.sv
// Sample stream from the capture sequencer to downstream DSP/FIFO logic.
interface ltc2292_ctrl_if;
  import ltc2292_pkg::*;

  logic [PAIR_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/ltc2292_out_reg.sv
// Single-entry valid/ready output register; a sample offered while the entry is
// held and not accepted is dropped and flagged in a sticky overflow bit.
module ltc2292_out_reg
  import ltc2292_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              take,
  input  pair_t             din,
  input  logic              clr_ovf,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [PAIR_W-1:0] m_data,
  output logic              overflow
);

  logic              valid_q;
  logic [PAIR_W-1:0] data_q;
  logic              ovf_q;
  logic              load;

  assign load = take && (!valid_q || m_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= din;
      end else if (m_ready) begin
        valid_q <= 1'b0;
      end
      // A drop coinciding with a new start still records the loss.
      if (take && !load) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ltc2292_ctrl.sv
// LTC2292 capture sequencer: power/OE sequencing, pipeline flush, counted capture.
// Optional test pattern source enabled by defining LTC2292_CTRL_TESTPAT_EN.
module ltc2292_ctrl
  import ltc2292_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES  = 4096,
  parameter int unsigned PIPE_CYCLES  = 8,
  parameter int unsigned IDLE_TIMEOUT = 65535,
  parameter int unsigned SAMP_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  adc_dao,
  input  logic [ADC_W-1:0]  adc_dbo,
  output logic              adc_shdn,
  output logic              adc_oe_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SAMP_W-1:0] num_samples,
`ifdef LTC2292_CTRL_TESTPAT_EN
  input  logic              testpat,
`endif
  output logic              busy,
  output logic              done,
  output logic              overflow,
  ltc2292_ctrl_if.master    m_if
);

  localparam int unsigned WakeLast = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
  localparam int unsigned PipeLast = (PIPE_CYCLES > 0) ? PIPE_CYCLES - 1 : 0;
  localparam int unsigned IdleLast = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

  state_t            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic [SAMP_W-1:0] scnt_q, scnt_d, scnt_inc;
  logic [SAMP_W-1:0] num_q, num_d;
  logic              done_q, done_d;
  logic              take_q, take_d;
  pair_t             pair_q, pair_d;
  pair_t             adc_pair;
  logic              accept;

`ifdef LTC2292_CTRL_TESTPAT_EN
  logic tp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_q <= 1'b0;
    end else if (accept) begin
      tp_q <= testpat;
    end
  end

  always_comb begin
    if (tp_q) begin
      adc_pair.a = ADC_W'(scnt_q);
      adc_pair.b = ~ADC_W'(scnt_q);
    end else begin
      adc_pair.a = adc_dao;
      adc_pair.b = adc_dbo;
    end
  end
`else
  assign adc_pair = '{a: adc_dao, b: adc_dbo};
`endif

  assign scnt_inc = scnt_q + SAMP_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    scnt_d  = scnt_q;
    num_d   = num_q;
    done_d  = 1'b0;
    take_d  = 1'b0;
    pair_d  = pair_q;
    accept  = 1'b0;
    case (state_q)
      StShdn: begin
        if (start && !stop) begin
          accept  = 1'b1;
          state_d = StWake;
          timer_d = '0;
        end
      end
      StWake: begin
        if (stop) begin
          state_d = StShdn;
          done_d  = 1'b1;
        end else if (timer_q == WakeLast) begin
          state_d = (PIPE_CYCLES == 0) ? StCapture : StFlush;
          timer_d = '0;
          scnt_d  = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StFlush: begin
        if (stop) begin
          state_d = StShdn;
          done_d  = 1'b1;
        end else if (timer_q == PipeLast) begin
          state_d = StCapture;
          scnt_d  = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StCapture: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
          timer_d = '0;
        end else begin
          // Counter advances even if the output register drops this pair.
          take_d = 1'b1;
          pair_d = adc_pair;
          scnt_d = scnt_inc;
          if ((num_q != '0) && (scnt_inc == num_q)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            timer_d = '0;
          end
        end
      end
      StIdle: begin
        if (start && !stop) begin
          accept  = 1'b1;
          state_d = StCapture;
          scnt_d  = '0;
        end else if ((IDLE_TIMEOUT != 0) && (timer_q == IdleLast)) begin
          state_d = StShdn;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = StShdn;
    endcase
    if (accept) begin
      num_d = num_samples;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StShdn;
      timer_q <= '0;
      scnt_q  <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      take_q  <= 1'b0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      scnt_q  <= scnt_d;
      num_q   <= num_d;
      done_q  <= done_d;
      take_q  <= take_d;
      pair_q  <= pair_d;
    end
  end

  assign adc_shdn = (state_q == StShdn);
  assign adc_oe_n = (state_q == StShdn) || (state_q == StWake);
  assign busy     = (state_q == StWake) || (state_q == StFlush) || (state_q == StCapture);
  assign done     = done_q;

  ltc2292_out_reg u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .take     (take_q),
    .din      (pair_q),
    .clr_ovf  (accept),
    .m_ready  (m_if.m_ready),
    .m_valid  (m_if.m_valid),
    .m_data   (m_if.m_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_ltc2292_ctrl.sv
// Scoreboard bench for ltc2292_ctrl: spec-level reference model predicts pins and beats.
module tb_ltc2292_ctrl;
  import ltc2292_pkg::*;

  localparam int unsigned WAKE = 16;
  localparam int unsigned PIPE = 8;
  localparam int unsigned TMO  = 32;
  localparam int unsigned SW   = 16;

  localparam int PhOff = 0, PhWaking = 1, PhFlushing = 2, PhCapturing = 3, PhIdle = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   adc_dao = '0, adc_dbo = '0;
  logic          adc_shdn, adc_oe_n;
  logic          start = 1'b0, stop = 1'b0;
  logic [SW-1:0] num_samples = '0;
  logic          testpat = 1'b0;
  logic          busy, done, overflow;
  logic          m_ready = 1'b1;

  ltc2292_ctrl_if m_if ();
  assign m_if.m_ready = m_ready;

  ltc2292_ctrl #(
    .WAKE_CYCLES  (WAKE),
    .PIPE_CYCLES  (PIPE),
    .IDLE_TIMEOUT (TMO),
    .SAMP_W       (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_dao     (adc_dao),
    .adc_dbo     (adc_dbo),
    .adc_shdn    (adc_shdn),
    .adc_oe_n    (adc_oe_n),
    .start       (start),
    .stop        (stop),
    .num_samples (num_samples),
`ifdef LTC2292_CTRL_TESTPAT_EN
    .testpat     (testpat),
`endif
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .m_if        (m_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 random
  bit ramp = 1'b0;

  // Reference model state
  int            ph = PhOff;
  int            wake_left, flush_left, idle_age;
  logic [SW-1:0] taken, num_m;
  bit            tp_m;
  bit            pend_take = 1'b0;
  logic [23:0]   pend;
  bit            e_valid = 1'b0, e_ovf = 1'b0, e_done = 1'b0;
  logic [23:0]   sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Input drivers, updated just after each rising edge
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 2) m_ready = 1'($urandom);
    else m_ready = (rdy_mode == 1);
    if (ramp) begin
      adc_dao = adc_dao + 12'd1;
      adc_dbo = adc_dbo - 12'd3;
    end else begin
      adc_dao = 12'($urandom);
      adc_dbo = 12'($urandom);
    end
  end

  always @(posedge clk) begin : model
    bit acc, drop;
    acc  = 1'b0;
    drop = 1'b0;
    if (!rst_n) begin
      ph = PhOff;
      pend_take = 1'b0;
      e_valid = 1'b0;
      e_ovf = 1'b0;
      e_done = 1'b0;
      sb.delete();
    end else begin
      if (pend_take) begin
        if (!e_valid || m_ready) begin
          e_valid = 1'b1;
          sb.push_back(pend);
        end else begin
          drop = 1'b1;
        end
      end else if (m_ready) begin
        e_valid = 1'b0;
      end
      pend_take = 1'b0;
      e_done = 1'b0;
      case (ph)
        PhOff: if (start && !stop) begin
          acc = 1'b1;
          ph = PhWaking;
          wake_left = WAKE;
        end
        PhWaking: if (stop) begin
          ph = PhOff;
          e_done = 1'b1;
        end else begin
          wake_left--;
          if (wake_left == 0) begin
            ph = PhFlushing;
            flush_left = PIPE;
          end
        end
        PhFlushing: if (stop) begin
          ph = PhOff;
          e_done = 1'b1;
        end else begin
          flush_left--;
          if (flush_left == 0) begin
            ph = PhCapturing;
            taken = '0;
          end
        end
        PhCapturing: if (stop) begin
          ph = PhIdle;
          e_done = 1'b1;
          idle_age = 0;
        end else begin
          pend_take = 1'b1;
          pend = tp_m ? {taken[11:0], ~taken[11:0]} : {adc_dao, adc_dbo};
          taken = taken + 1'b1;
          if (num_m != 0 && taken == num_m) begin
            ph = PhIdle;
            e_done = 1'b1;
            idle_age = 0;
          end
        end
        default: if (start && !stop) begin
          acc = 1'b1;
          ph = PhCapturing;
          taken = '0;
        end else begin
          idle_age++;
          if (TMO != 0 && idle_age == TMO) ph = PhOff;
        end
      endcase
      if (acc) begin
        num_m = num_samples;
`ifdef LTC2292_CTRL_TESTPAT_EN
        tp_m = testpat;
`else
        tp_m = 1'b0;
`endif
      end
      if (drop) e_ovf = 1'b1;
      else if (acc) e_ovf = 1'b0;
    end
  end

  // Monitor: pins every cycle, beats popped from the scoreboard on handshake
  always @(negedge clk) begin
    logic [23:0] exp_beat;
    if (chk_en) begin
      chk("adc_shdn", 32'(adc_shdn), 32'(ph == PhOff));
      chk("adc_oe_n", 32'(adc_oe_n), 32'(ph == PhOff || ph == PhWaking));
      chk("busy", 32'(busy), 32'(ph == PhWaking || ph == PhFlushing || ph == PhCapturing));
      chk("done", 32'(done), 32'(e_done));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("m_valid", 32'(m_if.m_valid), 32'(e_valid));
      if (m_if.m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL beat_unexpected: got %0h, expected no beat at %0t", m_if.m_data, $time);
        end else begin
          exp_beat = sb.pop_front();
          chk("m_data", 32'(m_if.m_data), 32'(exp_beat));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input int n);
    num_samples = SW'(n);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step(1);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_%s: done stayed 0 for %0d cycles, expected a done pulse", tag, bound);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step(3);
    chk_en = 1'b1;
    chk("reset_m_data", 32'(m_if.m_data), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Cold start, short capture
    pulse_start(4);
    wait_done(60, "basic");
    step(3);

    // Ramp data
    ramp = 1'b1;
    pulse_start(10);
    wait_done(30, "ramp");
    ramp = 1'b0;
    step(3);

    // Full backpressure
    rdy_mode = 0;
    pulse_start(5);
    wait_done(30, "bp");
    step(2);
    chk("ovf_set", 32'(overflow), 32'h1);
    rdy_mode = 1;
    step(3);
    pulse_start(3);
    chk("ovf_clr", 32'(overflow), 32'h0);
    wait_done(20, "after_bp");
    step(2);

    // Continuous then stop
    pulse_start(0);
    step(100);
    pulse_stop();
    chk("stop_done", 32'(done), 32'h1);
    step(5);

    // Idle timeout, then stop during wake
    step(40);
    chk("timeout_shdn", 32'(adc_shdn), 32'h1);
    pulse_start(2);
    step(5);
    pulse_stop();
    chk("wake_stop_done", 32'(done), 32'h1);
    chk("wake_stop_shdn", 32'(adc_shdn), 32'h1);
    step(3);

    // Start just before timeout goes straight to capture
    pulse_start(1);
    wait_done(60, "one");
    step(30);
    pulse_start(3);
    chk("late_start_oe", 32'(adc_oe_n), 32'h0);
    wait_done(10, "late_start");
    step(2);

    // start+stop together, start while busy
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'h0);
    pulse_start(20);
    step(2);
    pulse_start(1);
    wait_done(40, "busy_start");
    step(3);

    // Random traffic
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      start = (r < 4);
      stop = (r >= 97);
      num_samples = SW'($urandom_range(0, 12));
      testpat = 1'($urandom);
      step(1);
    end
    start = 1'b0;
    stop = 1'b0;
    testpat = 1'b0;

    // Reset mid capture
    rdy_mode = 1;
    pulse_stop();
    step(3);
    pulse_start(50);
    step(40);
    rst_n = 1'b0;
    step(1);
    chk("rst_shdn", 32'(adc_shdn), 32'h1);
    chk("rst_oe_n", 32'(adc_oe_n), 32'h1);
    chk("rst_m_valid", 32'(m_if.m_valid), 32'h0);
    chk("rst_m_data", 32'(m_if.m_data), 32'h0);
    rst_n = 1'b1;
    step(5);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ltc2292_ctrl.md
Name: ltc2292_ctrl

Overview:
Capture sequencer for the LTC2292 dual 12-bit ADC interface block.
- Drives the ADC shutdown and output-enable pins and waits out wake-up and pipeline latency.
- Captures a programmed number of A/B sample pairs per start request and streams them over a valid/ready interface.
- Sits between the ltc2292 capture block (whose dao/dbo feed it) and downstream DSP/FIFO logic. Handles power gating on idle timeout.

Parameters:
WAKE_CYCLES, 4096, clk cycles held after deasserting shutdown before enabling outputs
PIPE_CYCLES, 8, samples discarded after output enable (ADC pipeline plus interface latency)
IDLE_TIMEOUT, 65535, idle cycles with ADC awake before automatic shutdown; 0 disables timeout
SAMP_W, 16, width of sample-count request

Ports:
clk  in  1  system clock, same as ADC sample clock
rst_n  in  1  synchronous active-low reset
adc_dao  in  12  channel A sample (two's complement) from interface block
adc_dbo  in  12  channel B sample (two's complement) from interface block
adc_shdn  out  1  ADC SHDN pin, 1 = shutdown
adc_oe_n  out  1  ADC OE pin, active low
start  in  1  single-cycle capture request
stop  in  1  single-cycle abort request
num_samples  in  SAMP_W  pairs to capture, sampled on accepted start; 0 = continuous until stop
busy  out  1  high in WAKE, FLUSH, CAPTURE
done  out  1  one-cycle pulse when a capture completes or is stopped
overflow  out  1  sticky: at least one sample dropped due to backpressure
m_data  out  24  {A[11:0], B[11:0]}
m_valid  out  1  output register holds a sample
m_ready  in  1  downstream accepts

Behaviour:
- Reset (rst_n low at a clk edge):
  - State SHDN.
  - adc_shdn=1, adc_oe_n=1.
  - busy=0, done=0, overflow=0, m_valid=0, m_data=0.
  - All counters cleared.
- SHDN: adc_shdn=1, adc_oe_n=1. start -> WAKE, adc_shdn=0, load wake counter.
- WAKE: count WAKE_CYCLES cycles, then adc_oe_n=0 and enter FLUSH.
- FLUSH: discard exactly PIPE_CYCLES samples, then enter CAPTURE.
- CAPTURE:
  - One pair is taken every cycle.
  - Counter increments on every cycle, including dropped samples.
  - When count reaches num_samples (nonzero) -> IDLE with a done pulse.
- IDLE:
  - ADC awake (adc_shdn=0, adc_oe_n=0).
  - start -> CAPTURE directly; no flush, because the pipeline is already valid.
  - Idle counter reaching IDLE_TIMEOUT -> SHDN.
- start acceptance:
  - Accepted only in SHDN or IDLE; ignored while busy.
  - Acceptance latches num_samples and clears overflow.
- stop:
  - In CAPTURE -> IDLE with a done pulse.
  - In WAKE or FLUSH -> SHDN with a done pulse.
  - Ignored in SHDN/IDLE.
  - stop and start in the same cycle: stop wins; start is dropped.
- Output register:
  - Sample at edge t is visible on m_data with m_valid=1 after edge t+1.
  - Loaded when m_valid=0 or m_ready=1.
  - Otherwise the sample is dropped and overflow set.
  - m_data is stable while m_valid && !m_ready.
  - A pending sample remains deliverable after the capture ends.
- Continuous mode (num_samples=0): no count termination; only stop ends capture. Counter wraps silently.
- Timeout counter resets on every entry to IDLE.

Optional Feature:
LTC2292_CTRL_TESTPAT_EN
- With the macro: extra input port testpat (1 bit). When high at start acceptance, captured data is replaced by an internal 12-bit counter: A=cnt, B=~cnt, where cnt starts at 0 on the first CAPTURE sample and increments per capture cycle, including dropped samples. Sequencing is unchanged.
- Without the macro: no testpat port; ADC data always passed.

Decomposition:
- Shared package ltc2292_pkg:
  - State enum (SHDN, WAKE, FLUSH, CAPTURE, IDLE).
  - Sample width constant ADC_W=12.
  - Packed pair typedef {a,b}.
- One sub-module, ltc2292_out_reg: single-entry valid/ready output register with drop/overflow flag.

Test Plan:
- Reset then start, num_samples=4, WAKE_CYCLES=16, PIPE_CYCLES=8, m_ready=1 -> adc_shdn low after 1 cycle; adc_oe_n low 16 cycles later; 8 samples discarded; exactly 4 beats; one done pulse; busy low; state IDLE.
- Ramp on adc_dao/dbo, capture 10 with m_ready=1 -> m_data beats match inputs 1 cycle delayed; overflow=0.
- m_ready=0 throughout capture of 5 -> first sample held on m_data; 4 drops; overflow=1; clears on next accepted start.
- num_samples=0, stop after 100 captures -> done pulse; IDLE; no further beats. Stop during WAKE -> SHDN; adc_shdn=1.
- IDLE_TIMEOUT=32, no start -> adc_shdn=1 and adc_oe_n=1 after 32 idle cycles. Start at cycle 31 -> CAPTURE without wake/flush.
- start+stop same cycle in IDLE -> no capture. Start while busy -> ignored. rst_n low mid-CAPTURE -> all outputs at reset values next edge.
